// File: rtl/irq_trap_ctrl_if.sv
// Trap request handshake between the trap controller and the CSR block.
// Master raises the request with cause; slave acknowledges once CSRs are written.
interface irq_trap_ctrl_if;
  logic       trap_req;
  logic       trap_irq;
  logic [3:0] trap_code;
  logic       trap_ack;

  modport master (
    output trap_req,
    output trap_irq,
    output trap_code,
    input  trap_ack
  );

  modport slave (
    input  trap_req,
    input  trap_irq,
    input  trap_code,
    output trap_ack
  );
endinterface

// File: rtl/irq_trap_ctrl.sv
// Interrupt/exception trap sequencer: IDLE -> REQ -> FLUSH, with saturating trap count.
// Define IRQ_SYNC_EN to pass raw interrupt lines through 2-flop synchronizers.
module irq_trap_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             RSTN,
  input  logic             meip_in,
  input  logic             mtip_in,
  input  logic             msip_in,
  input  logic             meie,
  input  logic             mtie,
  input  logic             msie,
  input  logic             mie_global,
  input  logic             exc_valid,
  input  logic [3:0]       exc_code,
  input  logic             boundary,
  input  logic             mret,
  irq_trap_ctrl_if.master  trap_if,
  output logic             flush,
  output logic             stall_if,
  output logic [2:0]       irq_pend,
  output logic [CNT_W-1:0] trap_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam logic [3:0] FLUSH_LD = 4'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             req_q, req_d;
  logic             irq_q, irq_d;
  logic [3:0]       code_q, code_d;
  logic [3:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       lvl;
  logic [3:0]       irq_code;
  logic             irq_claim;

`ifdef IRQ_SYNC_EN
  logic [2:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {meip_in, mtip_in, msip_in};
      sync2_q <= sync1_q;
    end
  end

  assign lvl = sync2_q;
`else
  assign lvl = {meip_in, mtip_in, msip_in};
`endif

  assign irq_pend  = lvl & {meie, mtie, msie};
  assign irq_claim = (|irq_pend) & mie_global;

  // Fixed priority MEI > MTI > MSI
  always_comb begin
    if (irq_pend[2])      irq_code = 4'd11;
    else if (irq_pend[1]) irq_code = 4'd7;
    else                  irq_code = 4'd3;
  end

  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    code_d  = code_q;
    fcnt_d  = fcnt_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (exc_valid) begin
          irq_d   = 1'b0;
          code_d  = exc_code;
          state_d = REQ;
        end else if (mret) begin
          fcnt_d  = FLUSH_LD;
          state_d = FLUSH;
        end else if (irq_claim && boundary) begin
          irq_d   = 1'b1;
          code_d  = irq_code;
          state_d = REQ;
        end
      end
      REQ: begin
        if (trap_if.trap_ack) begin
          fcnt_d  = FLUSH_LD;
          state_d = FLUSH;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_ONE;
        end
      end
      FLUSH: begin
        if (fcnt_q <= 4'd1) begin
          fcnt_d  = '0;
          state_d = IDLE;
        end else begin
          fcnt_d  = fcnt_q - 4'd1;
        end
      end
      default: begin
        fcnt_d  = '0;
        state_d = IDLE;
      end
    endcase
    req_d = (state_d == REQ);
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      irq_q   <= 1'b0;
      code_q  <= '0;
      fcnt_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      irq_q   <= irq_d;
      code_q  <= code_d;
      fcnt_q  <= fcnt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign trap_if.trap_req  = req_q;
  assign trap_if.trap_irq  = irq_q;
  assign trap_if.trap_code = code_q;
  assign flush             = (state_q == FLUSH);
  assign stall_if          = (state_q != IDLE);
  assign trap_cnt          = cnt_q;

endmodule

// File: tb/tb_irq_trap_ctrl.sv
// Directed bench for irq_trap_ctrl: default instance (flush 2, 16-bit count)
// and a second instance (flush 3, 2-bit count) driven by the same stimulus.
module tb_irq_trap_ctrl;

  logic       clk = 1'b0;
  logic       RSTN;
  logic       meip_in, mtip_in, msip_in;
  logic       meie, mtie, msie, mie_global;
  logic       exc_valid;
  logic [3:0] exc_code;
  logic       boundary, mret, ack;

  logic        fl_a, st_a, fl_b, st_b;
  logic [2:0]  pend_a, pend_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  int n_run  = 0;
  int n_fail = 0;
  int exp_a  = 0;
  int exp_b  = 0;

  irq_trap_ctrl_if ifa ();
  irq_trap_ctrl_if ifb ();

  assign ifa.trap_ack = ack;
  assign ifb.trap_ack = ack;

  irq_trap_ctrl u_dut_a (
    .clk(clk), .RSTN(RSTN),
    .meip_in(meip_in), .mtip_in(mtip_in), .msip_in(msip_in),
    .meie(meie), .mtie(mtie), .msie(msie),
    .mie_global(mie_global),
    .exc_valid(exc_valid), .exc_code(exc_code),
    .boundary(boundary), .mret(mret),
    .trap_if(ifa.master),
    .flush(fl_a), .stall_if(st_a),
    .irq_pend(pend_a), .trap_cnt(cnt_a)
  );

  irq_trap_ctrl #(.FLUSH_CYCLES(3), .CNT_W(2)) u_dut_b (
    .clk(clk), .RSTN(RSTN),
    .meip_in(meip_in), .mtip_in(mtip_in), .msip_in(msip_in),
    .meie(meie), .mtie(mtie), .msie(msie),
    .mie_global(mie_global),
    .exc_valid(exc_valid), .exc_code(exc_code),
    .boundary(boundary), .mret(mret),
    .trap_if(ifb.master),
    .flush(fl_b), .stall_if(st_b),
    .irq_pend(pend_b), .trap_cnt(cnt_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    meip_in = 0; mtip_in = 0; msip_in = 0;
    exc_valid = 0; exc_code = 0;
    boundary = 0; mret = 0; ack = 0;
  endtask

  task automatic count_flush(input string tag);
    int fa = 0;
    int fb = 0;
    for (int i = 0; i < 8; i++) begin
      fa += int'(fl_a);
      fb += int'(fl_b);
      tick();
    end
    chk({tag, "_flen_a"}, fa, 2);
    chk({tag, "_flen_b"}, fb, 3);
    chk({tag, "_stall_a"}, st_a, 0);
    chk({tag, "_stall_b"}, st_b, 0);
  endtask

  task automatic do_ack(input string tag);
    ack = 1;
    tick();
    ack = 0;
    exp_a = exp_a + 1;
    exp_b = (exp_b == 3) ? 3 : exp_b + 1;
    chk({tag, "_req_off"}, ifa.trap_req, 0);
    chk({tag, "_cnt_a"}, cnt_a, exp_a);
    chk({tag, "_cnt_b"}, cnt_b, exp_b);
    count_flush(tag);
  endtask

  initial begin
    RSTN = 0;
    meie = 0; mtie = 0; msie = 0; mie_global = 0;
    idle_in();
    repeat (3) tick();
    chk("rst_req", ifa.trap_req, 0);
    chk("rst_irq", ifa.trap_irq, 0);
    chk("rst_code", ifa.trap_code, 0);
    chk("rst_flush", fl_a, 0);
    chk("rst_stall", st_a, 0);
    chk("rst_pend", pend_a, 0);
    chk("rst_cnt_b", cnt_b, 0);
    RSTN = 1;
    tick();

    // synchronous exception, ack held off one cycle
    exc_valid = 1; exc_code = 4'd2;
    tick();
    exc_valid = 0;
    chk("exc_req", ifa.trap_req, 1);
    chk("exc_irq", ifa.trap_irq, 0);
    chk("exc_code", ifa.trap_code, 2);
    chk("exc_stall", st_a, 1);
    chk("exc_noflush", fl_a, 0);
    tick();
    chk("exc_hold", ifa.trap_req, 1);
    do_ack("exc");

    // interrupt priority
    meie = 1; mtie = 1; msie = 1; mie_global = 1;
    meip_in = 1; mtip_in = 1; msip_in = 1;
    #1;
    chk("pend_all", pend_a, 3'b111);
    boundary = 1;
    tick();
    idle_in();
    chk("mei_req", ifb.trap_req, 1);
    chk("mei_irq", ifa.trap_irq, 1);
    chk("mei_code", ifa.trap_code, 11);
    do_ack("mei");

    mtip_in = 1; msip_in = 1; boundary = 1;
    tick();
    idle_in();
    chk("mti_code", ifa.trap_code, 7);
    chk("mti_irq", ifb.trap_irq, 1);
    do_ack("mti");

    msip_in = 1; boundary = 1;
    tick();
    idle_in();
    chk("msi_code", ifa.trap_code, 3);
    do_ack("msi");

    // exception wins over a claimable interrupt
    meip_in = 1; boundary = 1;
    exc_valid = 1; exc_code = 4'd5;
    tick();
    idle_in();
    chk("pri_irq", ifa.trap_irq, 0);
    chk("pri_code", ifa.trap_code, 5);
    do_ack("pri");

    // cause held while line/enable drop; exception in REQ ignored
    meip_in = 1; boundary = 1;
    tick();
    idle_in();
    meie = 0;
    exc_valid = 1; exc_code = 4'd9;
    tick();
    exc_valid = 0;
    chk("hold_req", ifa.trap_req, 1);
    chk("hold_code", ifa.trap_code, 11);
    chk("hold_irq", ifa.trap_irq, 1);
    meie = 1;
    do_ack("hold");
    chk("keep_code", ifa.trap_code, 11);

    // not at boundary: no request for 5 cycles
    meip_in = 1; boundary = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("nobnd_req", ifa.trap_req, 0);
    end
    boundary = 1;
    tick();
    idle_in();
    chk("bnd_req", ifa.trap_req, 1);
    do_ack("bnd");

    // global disable blocks claim
    mie_global = 0; meip_in = 1; boundary = 1;
    tick();
    tick();
    chk("gdis_req", ifa.trap_req, 0);
    idle_in();
    mie_global = 1;

    // ack outside REQ ignored
    ack = 1;
    tick();
    ack = 0;
    chk("stray_ack_cnt", cnt_a, exp_a);
    chk("stray_ack_fl", fl_a, 0);

    // mret flush, count unchanged
    mret = 1;
    tick();
    mret = 0;
    chk("mret_req", ifa.trap_req, 0);
    count_flush("mret");
    chk("mret_cnt_a", cnt_a, exp_a);
    chk("mret_cnt_b", cnt_b, exp_b);

    // asynchronous reset in the middle of a flush
    exc_valid = 1; exc_code = 4'd4;
    tick();
    exc_valid = 0;
    ack = 1;
    tick();
    ack = 0;
    chk("pre_rst_fl", fl_b, 1);
    #2;
    RSTN = 0;
    #1;
    chk("arst_flush", fl_b, 0);
    chk("arst_stall", st_b, 0);
    chk("arst_req", ifb.trap_req, 0);
    chk("arst_code", ifb.trap_code, 0);
    chk("arst_cnt_a", cnt_a, 0);
    chk("arst_cnt_b", cnt_b, 0);
    tick();
    RSTN = 1;
    exc_valid = 1; exc_code = 4'd6;
    tick();
    exc_valid = 0;
    chk("post_rst_req", ifa.trap_req, 1);
    chk("post_rst_code", ifa.trap_code, 6);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_trap_ctrl.md
IRQ_TRAP_CTRL -- requirements
Module: irq_trap_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2, pipeline flush length in cycles after trap entry or mret (legal 1..15).
REQ-002 Parameter CNT_W, default 16, width of trap statistics counter.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 RSTN  in  1  reset, asynchronous, active-low.
REQ-005 meip_in, mtip_in, msip_in  in  1 each  raw interrupt levels (external, timer, software).
REQ-006 meie, mtie, msie  in  1 each  per-source enables (mie bits 11/7/3).
REQ-007 mie_global  in  1  mstatus.MIE global enable.
REQ-008 exc_valid  in  1  synchronous exception from EXE, single-cycle pulse.
REQ-009 exc_code  in  4  exception cause code, valid with exc_valid.
REQ-010 boundary  in  1  pipeline at instruction boundary (EXE_ready), interrupt may be taken.
REQ-011 trap_ack  in  1  CSR block has written mepc/mcause/mstatus for current trap.
REQ-012 mret  in  1  mret executing, single-cycle pulse.
REQ-013 trap_req  out  1  trap request to CSR block.
REQ-014 trap_irq  out  1  mcause.Interrupt bit of request.
REQ-015 trap_code  out  4  mcause code of request.
REQ-016 flush  out  1  pipeline flush.
REQ-017 stall_if  out  1  fetch stall, high whenever state != IDLE.
REQ-018 irq_pend  out  3  {MEI,MTI,MSI} sampled levels AND per-source enables.
REQ-019 trap_cnt  out  CNT_W  number of traps acknowledged, saturating.

Function
REQ-020 States: IDLE, REQ, FLUSH; one-hot or binary encoding free; unreachable encodings return to IDLE next cycle.
REQ-021 irq_claim = (|irq_pend) & mie_global; evaluated combinationally from sampled levels.
REQ-022 IDLE, exc_valid=1: latch trap_irq=0, trap_code=exc_code, go REQ; boundary ignored; exception has priority over any interrupt and over mret.
REQ-023 IDLE, exc_valid=0, irq_claim=1, boundary=1: latch trap_irq=1, code by fixed priority MEI(11) > MTI(7) > MSI(3), go REQ.
REQ-024 IDLE, irq_claim=1, boundary=0: remain IDLE, no request.
REQ-025 Latency: qualifying event in cycle N -> trap_req=1 in cycle N+1.
REQ-026 REQ: trap_req=1; trap_irq/trap_code held stable until ack even if interrupt lines or enables drop.
REQ-027 REQ, trap_ack=1: next state FLUSH, flush counter loaded with FLUSH_CYCLES, trap_cnt incremented.
REQ-028 trap_ack outside REQ ignored; exc_valid and mret outside IDLE ignored.
REQ-029 IDLE, mret=1 (exc_valid=0): go FLUSH with counter loaded, no trap_cnt change.
REQ-030 FLUSH: flush=1 for exactly FLUSH_CYCLES cycles, counter decrements each cycle, at 1 -> IDLE; flush=0 in IDLE and REQ.
REQ-031 trap_cnt saturates at all-ones; further acks leave it unchanged.
REQ-032 trap_req, trap_irq, trap_code are registered outputs; trap_irq/trap_code retain last value outside REQ.

Reset
REQ-033 RSTN low, at any time including mid-REQ or mid-FLUSH: state IDLE, trap_req=0, trap_irq=0, trap_code=0, flush=0, flush counter=0, trap_cnt=0, synchronizer flops=0; stall_if=0 and irq_pend=0 follow.
REQ-034 First event accepted on first rising edge after RSTN deasserts.

Configuration
REQ-035 Macro IRQ_SYNC_EN defined: meip_in/mtip_in/msip_in pass through 2-flop synchronizers; irq_pend lags raw input by 2 cycles, interrupt trap latency from raw edge = 3 cycles.
REQ-036 IRQ_SYNC_EN undefined: raw levels used directly; irq_pend combinational from inputs, latency per REQ-025.

Verification
REQ-037 exc_valid=1, exc_code=2 in IDLE -> next cycle trap_req=1, trap_irq=0, trap_code=2; ack -> flush high 2 cycles, trap_cnt=1.
REQ-038 meip_in=mtip_in=msip_in=1, all enables=1, mie_global=1, boundary=1 -> trap_code=11, trap_irq=1; repeat with meip_in=0 -> code 7.
REQ-039 exc_valid=1 and irq_claim=1 same cycle -> trap_irq=0, exc_code taken; meip_in drop during REQ -> trap_code stays 11.
REQ-040 irq_claim=1, boundary=0 for 5 cycles -> trap_req stays 0; boundary=1 -> trap_req next cycle.
REQ-041 mret in IDLE with FLUSH_CYCLES=3 -> flush high exactly 3 cycles, trap_cnt unchanged; RSTN low during FLUSH -> all outputs 0 immediately.
REQ-042 CNT_W=2, 5 acked traps -> trap_cnt=3 after third and stays 3.
